// File: rtl/time_keeper_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : time_keeper_if
// Brief    : Button inputs and registered time outputs of the timekeeping core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface time_keeper_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       pm;
    logic       sec_tick;
    logic [1:0] set_mode;

    modport master (
        output btn_mode, btn_inc,
        input  hours, mins, secs, pm, sec_tick, set_mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output hours, mins, secs, pm, sec_tick, set_mode
    );
endinterface
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : time_keeper
// Brief    : 1 Hz prescaler, 12-hour clock with AM/PM and two-button set FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module time_keeper #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  wire              clk,
    input  wire              rst,
    time_keeper_if.slave     bus
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] c_presc_last = CNT_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_mode_s1, r_mode_s2, r_mode_s3;
    logic             r_inc_s1,  r_inc_s2,  r_inc_s3;
    logic             w_mode_p;
    logic             w_inc_p;
    logic             w_inc_act;
    logic             w_tick;

    logic [CNT_W-1:0] r_presc;
    logic [3:0]       r_hours;
    logic [5:0]       r_mins;
    logic [5:0]       r_secs;
    logic             r_pm;
    logic             r_sec_tick;

    // Any out-of-range hour recovers to 1 so the sequence can never stick.
    function automatic logic [3:0] next_hour(input logic [3:0] h);
        if (h >= 4'd12 || h == 4'd0)
            return 4'd1;
        return h + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_s3 <= 1'b0;
            r_inc_s1  <= 1'b0;
            r_inc_s2  <= 1'b0;
            r_inc_s3  <= 1'b0;
        end else begin
            r_mode_s1 <= bus.btn_mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_s3 <= r_mode_s2;
            r_inc_s1  <= bus.btn_inc;
            r_inc_s2  <= r_inc_s1;
            r_inc_s3  <= r_inc_s2;
        end
    end

    assign w_mode_p  = r_mode_s2 & ~r_mode_s3;
    assign w_inc_p   = r_inc_s2  & ~r_inc_s3;
    assign w_inc_act = w_inc_p & ~w_mode_p;
    assign w_tick    = (r_state == RUN) && (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_mode_p) w_state_nxt = SET_H;
            SET_H:   if (w_mode_p) w_state_nxt = SET_M;
            SET_M:   if (w_mode_p) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_hours    <= 4'd12;
            r_mins     <= 6'd0;
            r_secs     <= 6'd0;
            r_pm       <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        if (r_secs >= 6'd59) begin
                            r_secs <= 6'd0;
                            if (r_mins >= 6'd59) begin
                                r_mins  <= 6'd0;
                                r_hours <= next_hour(r_hours);
                                if (r_hours == 4'd11)
                                    r_pm <= ~r_pm;
                            end else begin
                                r_mins <= r_mins + 6'd1;
                            end
                        end else begin
                            r_secs <= r_secs + 6'd1;
                        end
                    end else begin
                        r_presc <= r_presc + CNT_W'(1);
                    end
                    // Entering SET_H throws away the partial second.
                    if (w_mode_p)
                        r_presc <= '0;
                end
                SET_H: begin
                    r_presc <= '0;
                    if (w_inc_act) begin
                        r_hours <= next_hour(r_hours);
                        if (r_hours == 4'd11)
                            r_pm <= ~r_pm;
                    end
                end
                SET_M: begin
                    r_presc <= '0;
                    if (w_inc_act)
                        r_mins <= (r_mins >= 6'd59) ? 6'd0 : r_mins + 6'd1;
                    if (w_mode_p)
                        r_secs <= 6'd0;
                end
                default: r_presc <= '0;
            endcase
        end
    end

    assign bus.hours    = r_hours;
    assign bus.mins     = r_mins;
    assign bus.secs     = r_secs;
    assign bus.pm       = r_pm;
    assign bus.sec_tick = r_sec_tick;
    assign bus.set_mode = r_state;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_time_keeper
// Brief    : Scoreboard bench for time_keeper with TICKS_PER_SEC = 4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_time_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    time_keeper_if bus();

    time_keeper #(.TICKS_PER_SEC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       pm;
        logic [1:0] md;
    } snap_t;

    snap_t exp_q[$];
    int    exp_secs_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    saw_tick;

    function automatic snap_t cur();
        return {bus.hours, bus.mins, bus.secs, bus.pm, bus.set_mode};
    endfunction

    function automatic snap_t mk(input int h, input int m, input int s,
                                 input int pm, input int md);
        snap_t r;
        r.h = 4'(h); r.m = 6'(m); r.s = 6'(s); r.pm = 1'(pm); r.md = 2'(md);
        return r;
    endfunction

    // One clock edge; the bench samples and drives 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.sec_tick) saw_tick = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press(input bit is_inc, input int post);
        if (is_inc) bus.btn_inc = 1'b1; else bus.btn_mode = 1'b1;
        repeat (3) step();
        bus.btn_inc  = 1'b0;
        bus.btn_mode = 1'b0;
        repeat (post) step();
    endtask

    task automatic wait_ticks(input int n);
        int got = 0;
        for (int k = 0; k < n * 4 + 16 && got < n; k++) begin
            step();
            if (bus.sec_tick) got++;
        end
        n_cmp++;
        if (got !== n) begin
            n_err++;
            $display("FAIL wait_ticks: got %0d ticks want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        snap_t e;
        do_reset();
        e = mk(12, 0, 0, 0, 0);
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", cur(), e);
        end
        n_cmp++;
        if (bus.sec_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick: got %b want 0", bus.sec_tick);
        end
    endtask

    task automatic test_free_run();
        logic exp_tick;
        int   s;
        do_reset();
        for (int i = 1; i <= 3; i++) exp_secs_q.push_back(i);
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_tick = (c % 4 == 0);
            n_cmp++;
            if (bus.sec_tick !== exp_tick) begin
                n_err++;
                $display("FAIL free_run_tick c=%0d: got %b want %b", c, bus.sec_tick, exp_tick);
            end
            if (bus.sec_tick) begin
                n_cmp++;
                if (exp_secs_q.size() == 0) begin
                    n_err++;
                    $display("FAIL free_run_secs: got unexpected tick want none");
                end else begin
                    s = exp_secs_q.pop_front();
                    if (int'(bus.secs) !== s) begin
                        n_err++;
                        $display("FAIL free_run_secs: got %0d want %0d", bus.secs, s);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_secs_q.size() !== 0) begin
            n_err++;
            $display("FAIL free_run_missing: got %0d left want 0", exp_secs_q.size());
            exp_secs_q.delete();
        end
    endtask

    task automatic test_set_hours();
        logic [1:0] exp_md [3] = '{2'b00, 2'b00, 2'b01};
        snap_t e;
        do_reset();
        saw_tick = 1'b0;
        bus.btn_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (bus.set_mode !== exp_md[k]) begin
                n_err++;
                $display("FAIL mode_latency edge=%0d: got %b want %b", k + 1, bus.set_mode, exp_md[k]);
            end
        end
        bus.btn_mode = 1'b0;
        repeat (3) step();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mk(i, 0, 0, 0, 1));
            press(1'b1, 3);
            e = exp_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL set_hours inc%0d: got %h want %h", i, cur(), e);
            end
        end
        n_cmp++;
        if (saw_tick !== 1'b0) begin
            n_err++;
            $display("FAIL set_frozen_tick: got %b want 0", saw_tick);
        end
    endtask

    task automatic test_set_minutes();
        int    exp_m [3] = '{59, 0, 1};
        snap_t e;
        int    k;
        do_reset();
        press(1'b0, 3);
        press(1'b0, 3);
        repeat (58) press(1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(12, exp_m[i], 0, 0, 2));
            press(1'b1, 3);
            e = exp_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL set_mins inc%0d: got %h want %h", i, cur(), e);
            end
        end
        press(1'b0, 0);
        e = mk(12, 1, 0, 0, 0);
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL exit_set: got %h want %h", cur(), e);
        end
        for (k = 1; k <= 10; k++) begin
            step();
            if (bus.sec_tick) break;
        end
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL exit_tick_latency: got %0d want 4", k);
        end
    endtask

    task automatic test_carry();
        snap_t e;
        do_reset();
        press(1'b0, 3);
        repeat (11) press(1'b1, 3);
        press(1'b0, 3);
        repeat (59) press(1'b1, 3);
        press(1'b0, 0);
        exp_q.push_back(mk(11, 59, 59, 0, 0));
        exp_q.push_back(mk(12, 0, 0, 1, 0));
        exp_q.push_back(mk(12, 59, 59, 1, 0));
        exp_q.push_back(mk(1, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       wait_ticks(59);
                2:       wait_ticks(3599);
                default: wait_ticks(1);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL carry step%0d: got %h want %h", i, cur(), e);
            end
        end
    endtask

    task automatic test_simultaneous();
        snap_t e;
        do_reset();
        press(1'b0, 3);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (3) step();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (3) step();
        e = mk(12, 0, 0, 0, 2);
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL mode_beats_inc: got %h want %h", cur(), e);
        end
        bus.btn_inc = 1'b1;
        repeat (20) step();
        bus.btn_inc = 1'b0;
        repeat (3) step();
        e = mk(12, 1, 0, 0, 2);
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL held_inc: got %h want %h", cur(), e);
        end
    endtask

    task automatic test_reset_mid_set();
        snap_t e;
        int    k;
        do_reset();
        press(1'b0, 3);
        repeat (19) press(1'b1, 3);
        press(1'b0, 3);
        repeat (33) press(1'b1, 3);
        e = mk(7, 33, 0, 1, 2);
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL preset_0733pm: got %h want %h", cur(), e);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = mk(12, 0, 0, 0, 0);
        n_cmp++;
        if (cur() !== e || bus.sec_tick !== 1'b0) begin
            n_err++;
            $display("FAIL mid_set_reset: got %h tick %b want %h tick 0", cur(), bus.sec_tick, e);
        end
        for (k = 1; k <= 10; k++) begin
            step();
            if (bus.sec_tick) break;
        end
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL reset_presc_restart: got %0d want 4", k);
        end
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        saw_tick     = 1'b0;
        test_reset();
        test_free_run();
        test_set_hours();
        test_set_minutes();
        test_simultaneous();
        test_reset_mid_set();
        test_carry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
